// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small write FIFO.
// A 16x baud tick is derived from the clock, and each bit lasts 16 ticks.
// The baud code is captured at the start of every frame.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | line high, waiting for Tx_EN with a word queued
//   S_START  | start bit (0); head word popped into the shift register
//   S_DATA   | DATA_W data bits, LSB first
//   S_PARITY | parity bit (only reached when PARITY != 0)
//   S_STOP   | STOP_BITS stop bits (1); chains straight into the next START
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    baud_select,
  input  logic                          Tx_EN,
  input  logic                          Tx_WR,
  input  logic [DATA_W-1:0]             Tx_DATA,
  output logic                          TxD,
  output logic                          Tx_BUSY,
  output logic                          Tx_FULL,
  output logic [$clog2(FIFO_DEPTH):0]   Tx_LEVEL,
  output logic                          Tx_OVF
);

  // Rounded divider for one 16x tick at the selected rate.
  function automatic int baud_div(input logic [2:0] code);
    int rate;
    case (code)
      3'd0:    rate = 300;
      3'd1:    rate = 1200;
      3'd2:    rate = 4800;
      3'd3:    rate = 9600;
      3'd4:    rate = 19200;
      3'd5:    rate = 38400;
      3'd6:    rate = 57600;
      default: rate = 115200;
    endcase
    return (CLK_FREQ + 8 * rate) / (16 * rate);
  endfunction

  localparam int DIV_W = $clog2(baud_div(3'd0) + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_TAB [8] = '{
    DIV_W'(baud_div(3'd0)), DIV_W'(baud_div(3'd1)),
    DIV_W'(baud_div(3'd2)), DIV_W'(baud_div(3'd3)),
    DIV_W'(baud_div(3'd4)), DIV_W'(baud_div(3'd5)),
    DIV_W'(baud_div(3'd6)), DIV_W'(baud_div(3'd7))
  };

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level;
  logic               ovf;
  logic [DATA_W-1:0]  shreg;
  logic               par_bit;
  logic [DIV_W-1:0]   div_sel, div_lat, div_cnt;
  logic [3:0]         tick_cnt;
  logic [3:0]         bit_cnt;
  logic               stop_cnt;
  logic               full, wr_acc, tick, bit_end, start_go;

  assign div_sel  = DIV_TAB[baud_select];
  assign full     = (level == LVL_W'(FIFO_DEPTH));
  assign wr_acc   = Tx_WR && !full;
  assign tick     = (div_cnt == '0);
  assign bit_end  = tick && (tick_cnt == 4'd0);
  // Entering START is also the pop of the head word.
  assign start_go = (state_nxt == S_START) && (state != S_START);

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= Tx_DATA;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_acc)         wr_ptr <= wr_ptr + PTR_W'(1);
      if (start_go)       rd_ptr <= rd_ptr + PTR_W'(1);
      if (Tx_WR && full)  ovf    <= 1'b1;
      if (wr_acc && !start_go)      level <= level + LVL_W'(1);
      else if (!wr_acc && start_go) level <= level - LVL_W'(1);
    end
  end

  // Baud divider, tick/bit counters and shift register; all restart at START.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_lat  <= '0;
      div_cnt  <= '0;
      tick_cnt <= 4'd0;
      bit_cnt  <= 4'd0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else if (start_go) begin
      div_lat  <= div_sel;
      div_cnt  <= div_sel - DIV_W'(1);
      tick_cnt <= 4'd15;
      bit_cnt  <= 4'(DATA_W - 1);
      stop_cnt <= 1'(STOP_BITS - 1);
      shreg    <= mem[rd_ptr];
      par_bit  <= (^mem[rd_ptr]) ^ (PARITY == 2);
    end else if (state != S_IDLE) begin
      div_cnt <= tick ? div_lat - DIV_W'(1) : div_cnt - DIV_W'(1);
      // tick_cnt wraps 0 -> 15, which is exactly the reload for the next bit
      if (tick) tick_cnt <= tick_cnt - 4'd1;
      if (bit_end && state == S_DATA) begin
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt - 4'd1;
      end
      if (bit_end && state == S_STOP) stop_cnt <= stop_cnt - 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (Tx_EN && level != '0) state_nxt = S_START;
      S_START:  if (bit_end) state_nxt = S_DATA;
      S_DATA:   if (bit_end && bit_cnt == 4'd0)
                  state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_nxt = S_STOP;
      S_STOP:   if (bit_end && stop_cnt == 1'b0)
                  state_nxt = (Tx_EN && level != '0) ? S_START : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state and datapath.
  always_comb begin
    TxD = 1'b1;
    case (state)
      S_START:  TxD = 1'b0;
      S_DATA:   TxD = shreg[0];
      S_PARITY: TxD = par_bit;
      default:  TxD = 1'b1;
    endcase
    Tx_BUSY  = (state != S_IDLE) || (level != '0);
    Tx_FULL  = full;
    Tx_LEVEL = level;
    Tx_OVF   = ovf;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed frame checks on two 50 MHz instances and
// a randomized run on a fast-clock instance checked by a serial decoder model.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // instance 0: all defaults
  logic       rst0, en0, wr0, txd0, busy0, full0, ovf0;
  logic [2:0] bsel0, lvl0;
  logic [7:0] data0;
  // instance 1: odd parity, two stop bits
  logic       rst12, en1, wr1, txd1, busy1, full1, ovf1;
  logic [2:0] bsel1, lvl1;
  logic [7:0] data1;
  // instance 2: 7 data bits, even parity, divider 2 at code 7 (32-cycle bits)
  logic       en2, wr2, txd2, busy2, full2, ovf2;
  logic [2:0] bsel2, lvl2;
  logic [6:0] data2;

  uart_tx_fifo dut0 (
    .clk(clk), .reset(rst0), .baud_select(bsel0), .Tx_EN(en0), .Tx_WR(wr0),
    .Tx_DATA(data0), .TxD(txd0), .Tx_BUSY(busy0), .Tx_FULL(full0),
    .Tx_LEVEL(lvl0), .Tx_OVF(ovf0));

  uart_tx_fifo #(.PARITY(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(rst12), .baud_select(bsel1), .Tx_EN(en1), .Tx_WR(wr1),
    .Tx_DATA(data1), .TxD(txd1), .Tx_BUSY(busy1), .Tx_FULL(full1),
    .Tx_LEVEL(lvl1), .Tx_OVF(ovf1));

  uart_tx_fifo #(.CLK_FREQ(3686400), .DATA_W(7), .PARITY(1)) dut2 (
    .clk(clk), .reset(rst12), .baud_select(bsel2), .Tx_EN(en2), .Tx_WR(wr2),
    .Tx_DATA(data2), .TxD(txd2), .Tx_BUSY(busy2), .Tx_FULL(full2),
    .Tx_LEVEL(lvl2), .Tx_OVF(ovf2));

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic [2:0] lvl;
    logic       full;
    logic       ovf;
    logic       busy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic txd_of(input int w);
    case (w)
      0:       return txd0;
      1:       return txd1;
      default: return txd2;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  // Waits (bounded) for a start bit, then checks every cycle of the frame.
  // Returns with the bench on the first cycle after the frame.
  task automatic check_frame(input int w, input logic [8:0] d, input int dw,
                             input int pm, input int sb, input int bt,
                             input string name, output int lat);
    logic [11:0] bits;
    logic        p;
    int          nb, errs, busy_err;
    bits = '1;
    bits[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < dw; i++) begin
      bits[1+i] = d[i];
      p = p ^ d[i];
    end
    if (pm != 0) bits[1+dw] = (pm == 2) ? ~p : p;
    nb = 1 + dw + ((pm != 0) ? 1 : 0) + sb;
    lat = 0;
    busy_err = 0;
    while (txd_of(w) !== 1'b0 && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    if (txd_of(w) !== 1'b0) begin
      chk({name, " start timeout"}, 32'(txd_of(w)), 0);
      return;
    end
    for (int b = 0; b < nb; b++) begin
      errs = 0;
      for (int c = 0; c < bt; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (txd_of(w) !== bits[b]) errs++;
        if (busy_of(w) !== 1'b1) busy_err++;
      end
      chk($sformatf("%s bit%0d bad cycles", name, b), errs, 0);
    end
    chk({name, " busy in frame"}, busy_err, 0);
    @(negedge clk);
  endtask

  task automatic run_dut0();
    vec_t vecs[8];
    int   lat, low;
    vecs[0] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h11, 3'd1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 8'h22, 3'd2, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 8'hEE, 3'd2, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'h33, 3'd3, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h44, 3'd4, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 8'h55, 3'd4, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 8'h66, 3'd4, 1'b1, 1'b1, 1'b1};

    // single word 0x94
    en0 = 1'b1; bsel0 = 3'd7;
    wr0 = 1'b1; data0 = 8'h94;
    @(negedge clk); wr0 = 1'b0;
    chk("single level", lvl0, 1);
    chk("single busy early", busy0, 1);
    check_frame(0, 9'h094, 8, 0, 1, 432, "single", lat);
    chk("single start latency", lat, 1);
    chk("single busy after", busy0, 0);
    chk("single txd idle", txd0, 1);

    // back-to-back 0x94, 0xA1
    wr0 = 1'b1; data0 = 8'h94;
    @(negedge clk); data0 = 8'hA1;
    @(negedge clk); wr0 = 1'b0;
    chk("write+pop level", lvl0, 1);
    check_frame(0, 9'h094, 8, 0, 1, 432, "b2b first", lat);
    check_frame(0, 9'h0A1, 8, 0, 1, 432, "b2b second", lat);
    chk("b2b no gap", lat, 0);
    chk("b2b busy after", busy0, 0);

    // overflow with transmit disabled
    en0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr0 = vecs[i].wr; data0 = vecs[i].data;
      @(negedge clk);
      chk($sformatf("vec%0d level", i), lvl0, vecs[i].lvl);
      chk($sformatf("vec%0d full", i), full0, vecs[i].full);
      chk($sformatf("vec%0d ovf", i), ovf0, vecs[i].ovf);
      chk($sformatf("vec%0d busy", i), busy0, vecs[i].busy);
      chk($sformatf("vec%0d txd", i), txd0, 1);
    end
    wr0 = 1'b0;
    en0 = 1'b1;
    check_frame(0, 9'h011, 8, 0, 1, 432, "ovf w0", lat);
    chk("ovf w0 latency", lat, 1);
    check_frame(0, 9'h022, 8, 0, 1, 432, "ovf w1", lat);
    chk("ovf w1 gap", lat, 0);
    check_frame(0, 9'h033, 8, 0, 1, 432, "ovf w2", lat);
    chk("ovf w2 gap", lat, 0);
    check_frame(0, 9'h044, 8, 0, 1, 432, "ovf w3", lat);
    chk("ovf w3 gap", lat, 0);
    chk("ovf drained level", lvl0, 0);
    chk("ovf drained busy", busy0, 0);
    chk("ovf sticky", ovf0, 1);
    low = 0;
    repeat (1000) begin
      @(negedge clk);
      if (txd0 !== 1'b1) low++;
    end
    chk("dropped word silent", low, 0);

    // reset in the middle of a frame with a word still queued
    wr0 = 1'b1; data0 = 8'h5A;
    @(negedge clk); data0 = 8'hC3;
    @(negedge clk); wr0 = 1'b0;
    repeat (700) @(negedge clk);
    chk("pre-reset busy", busy0, 1);
    chk("pre-reset level", lvl0, 1);
    rst0 = 1'b1;
    @(negedge clk); rst0 = 1'b0;
    chk("reset txd", txd0, 1);
    chk("reset level", lvl0, 0);
    chk("reset busy", busy0, 0);
    chk("reset ovf", ovf0, 0);
    chk("reset full", full0, 0);
    wr0 = 1'b1; data0 = 8'h3C;
    @(negedge clk); wr0 = 1'b0;
    check_frame(0, 9'h03C, 8, 0, 1, 432, "after reset", lat);
    chk("after reset latency", lat, 1);
    chk("after reset busy", busy0, 0);

    // rate change mid-frame applies to the next frame only
    wr0 = 1'b1; data0 = 8'h94;
    @(negedge clk); data0 = 8'hA1;
    @(negedge clk); wr0 = 1'b0;
    fork
      begin
        repeat (1000) @(negedge clk);
        bsel0 = 3'd6;
      end
      check_frame(0, 9'h094, 8, 0, 1, 432, "rate old", lat);
    join
    check_frame(0, 9'h0A1, 8, 0, 1, 864, "rate new", lat);
    chk("rate new gap", lat, 0);
    chk("rate busy after", busy0, 0);
  endtask

  task automatic run_dut1();
    int lat;
    en1 = 1'b1; bsel1 = 3'd7;
    wr1 = 1'b1; data1 = 8'h01;
    @(negedge clk); wr1 = 1'b0;
    check_frame(1, 9'h001, 8, 2, 2, 432, "odd par 2 stop", lat);
    chk("par frame latency", lat, 1);
    chk("par busy after", busy1, 0);
  endtask

  // Random writes and enable toggling; the model decodes the line and keeps
  // a queue of accepted words and a count of frames seen.
  task automatic run_dut2();
    localparam int BT = 32;
    localparam int NB = 10;
    localparam int NW = 25;
    logic [6:0] q[$];
    logic [6:0] w;
    logic [9:0] cap, expv;
    int  written, starts, frames, fc, model, cyc;
    int  lvl_err, full_err, busy_err, ovf_err, en_err;
    bit  in_frame, wr_prev, en_prev, done;
    written = 0; starts = 0; frames = 0; fc = 0; cyc = 0;
    lvl_err = 0; full_err = 0; busy_err = 0; ovf_err = 0; en_err = 0;
    in_frame = 1'b0; wr_prev = 1'b0; cap = '0;
    en2 = 1'b1; bsel2 = 3'd7; wr2 = 1'b0; data2 = '0;
    en_prev = 1'b1;
    done = 1'b0;
    while (cyc < 20000 && !done) begin
      @(negedge clk);
      cyc++;
      if (wr_prev) written++;
      if (in_frame) begin
        fc++;
        if (fc == NB * BT) begin
          in_frame = 1'b0;
          frames++;
          chk($sformatf("rand frame %0d had queued word", frames), (q.size() > 0), 1);
          if (q.size() > 0) begin
            w = q.pop_front();
            expv = {1'b1, ^w, w, 1'b0};
            chk($sformatf("rand frame %0d bits", frames), cap, expv);
          end
        end else if (fc % BT == BT / 2) begin
          cap[fc / BT] = txd2;
        end
      end
      if (!in_frame && txd2 === 1'b0) begin
        in_frame = 1'b1;
        fc = 0;
        starts++;
        if (!en_prev) en_err++;
      end
      model = written - starts;
      if (lvl2 !== 3'(model)) lvl_err++;
      if (full2 !== (model == 4)) full_err++;
      if (busy2 !== (in_frame || model > 0)) busy_err++;
      if (ovf2 !== 1'b0) ovf_err++;
      wr2 = 1'b0;
      if (written < NW && model < 4 && $urandom_range(0, 5) == 0) begin
        wr2 = 1'b1;
        data2 = 7'($urandom);
        q.push_back(data2);
      end
      if (written >= NW) en2 = 1'b1;
      else if ($urandom_range(0, 99) == 0) en2 = ~en2;
      wr_prev = wr2;
      en_prev = en2;
      done = (written == NW) && (starts == NW) && !in_frame && !wr2;
    end
    wr2 = 1'b0;
    chk("rand finished in budget", done, 1);
    chk("rand frame count", frames, NW);
    chk("rand level mismatches", lvl_err, 0);
    chk("rand full mismatches", full_err, 0);
    chk("rand busy mismatches", busy_err, 0);
    chk("rand ovf set", ovf_err, 0);
    chk("rand pop while disabled", en_err, 0);
  endtask

  initial begin
    rst0 = 1'b1; rst12 = 1'b1;
    en0 = 1'b0; wr0 = 1'b0; bsel0 = 3'd7; data0 = '0;
    en1 = 1'b0; wr1 = 1'b0; bsel1 = 3'd7; data1 = '0;
    en2 = 1'b0; wr2 = 1'b0; bsel2 = 3'd7; data2 = '0;
    repeat (3) @(negedge clk);
    chk("rst txd", txd0, 1);
    chk("rst busy", busy0, 0);
    chk("rst full", full0, 0);
    chk("rst level", lvl0, 0);
    chk("rst ovf", ovf0, 0);
    chk("rst txd par inst", txd1, 1);
    chk("rst txd fast inst", txd2, 1);
    rst0 = 1'b0; rst12 = 1'b0;
    fork
      run_dut0();
      run_dut1();
      run_dut2();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
